// File: rtl/band_fir_scheduler.sv
// Round-robin scheduler sharing one FIR MAC engine and coefficient ROM between N_REQ band queues.
// Per band it sequences start, accumulator clear, NUM_TAPS tap cycles, pipeline drain and done.
//   state | meaning
//   IDLE  | no window open; choose the next pending band round-robin from rr_ptr
//   GRANT | start strobe; the granted queue loads its window pointers
//   WAIT  | accum_clr while the queue's RAM read latency elapses
//   RUN   | seq high; coef_addr steps through the taps
//   DRAIN | MAC pipeline drain, PIPE_LAT cycles
//   DONE  | done pulse; release the band and advance rr_ptr
module band_fir_scheduler #(
  parameter int N_REQ    = 4,
  parameter int NUM_TAPS = 1021,
  parameter int TAP_W    = 11,
  parameter int PIPE_LAT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             ovr_clr,
  output logic [N_REQ-1:0] gnt,
  output logic             start,
  output logic             seq,
  output logic [TAP_W-1:0] coef_addr,
  output logic             accum_clr,
  output logic [N_REQ-1:0] done,
  output logic             busy,
  output logic [N_REQ-1:0] overrun
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int DW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [TAP_W-1:0] LAST_TAP   = TAP_W'(NUM_TAPS - 1);
  localparam logic [DW-1:0]    DRAIN_LOAD = DW'((PIPE_LAT > 0) ? PIPE_LAT - 1 : 0);
  localparam logic [PW-1:0]    LAST_REQ   = PW'(N_REQ - 1);

  typedef enum logic [2:0] {IDLE, GRANT, WAIT, RUN, DRAIN, DONE} state_t;

  state_t           state;
  logic [N_REQ-1:0] pending, pend_nxt, ovr_nxt;
  logic             requeue, requeue_nxt;
  logic [PW-1:0]    rr_ptr, win_idx, win_nxt, cand;
  logic [DW-1:0]    drain_cnt;

  // Lowest offset from rr_ptr wins, so scan offsets downward and let the last hit stand.
  always_comb begin
    win_nxt = rr_ptr;
    cand    = rr_ptr;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = PW'((int'(rr_ptr) + k) % N_REQ);
      if (pending[cand]) win_nxt = cand;
    end
  end

  // The band in service may queue one repeat request (requeue); anything beyond that overruns.
  always_comb begin
    pend_nxt    = pending;
    requeue_nxt = requeue;
    ovr_nxt     = ovr_clr ? '0 : overrun;
    for (int i = 0; i < N_REQ; i++) begin
      if (req[i]) begin
        if (gnt[i]) begin
          if (requeue) ovr_nxt[i] = 1'b1;
          else         requeue_nxt = 1'b1;
        end else if (pending[i]) begin
          ovr_nxt[i] = 1'b1;
        end else begin
          pend_nxt[i] = 1'b1;
        end
      end
    end
    if (state == DONE) begin
      pend_nxt    = (pend_nxt & ~gnt) | (gnt & {N_REQ{requeue_nxt}});
      requeue_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      requeue <= 1'b0;
      overrun <= '0;
    end else begin
      pending <= pend_nxt;
      requeue <= requeue_nxt;
      overrun <= ovr_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      win_idx   <= '0;
      drain_cnt <= '0;
      gnt       <= '0;
      start     <= 1'b0;
      seq       <= 1'b0;
      coef_addr <= '0;
      accum_clr <= 1'b0;
      done      <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|pending) begin
            win_idx <= win_nxt;
            gnt     <= N_REQ'(1) << win_nxt;
            start   <= 1'b1;
            busy    <= 1'b1;
            state   <= GRANT;
          end
        end
        GRANT: begin
          start     <= 1'b0;
          accum_clr <= 1'b1;
          state     <= WAIT;
        end
        WAIT: begin
          accum_clr <= 1'b0;
          seq       <= 1'b1;
          coef_addr <= '0;
          state     <= RUN;
        end
        RUN: begin
          if (coef_addr == LAST_TAP) begin
            seq       <= 1'b0;
            coef_addr <= '0;
            if (PIPE_LAT == 0) begin
              done  <= gnt;
              state <= DONE;
            end else begin
              drain_cnt <= DRAIN_LOAD;
              state     <= DRAIN;
            end
          end else begin
            coef_addr <= coef_addr + TAP_W'(1);
          end
        end
        DRAIN: begin
          if (drain_cnt == '0) begin
            done  <= gnt;
            state <= DONE;
          end else begin
            drain_cnt <= drain_cnt - DW'(1);
          end
        end
        DONE: begin
          done   <= '0;
          gnt    <= '0;
          busy   <= 1'b0;
          rr_ptr <= (win_idx == LAST_REQ) ? '0 : win_idx + PW'(1);
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
